// File: rtl/serial_subtractor.sv
// serial_subtractor: bit-serial WIDTH-bit subtractor computing diff = a - b, one bit per clock,
// LSB first, through a single full-subtractor cell and a borrow flip-flop.
//
// Ports:
//   clk     in   rising-edge clock
//   rst_n   in   asynchronous reset, active low
//   start   in   request; sampled only in IDLE or DONE
//   a, b    in   minuend / subtrahend, captured on the accepting edge
//   busy    out  high while a subtraction is in progress
//   done    out  single-cycle completion pulse
//   ovf     out  signed overflow (only with SERIAL_SUB_OVF_EN defined)
//   diff    out  a - b modulo 2^WIDTH, held until the next completion
//   borrow  out  unsigned borrow out (a < b)
//
// Configuration macro: SERIAL_SUB_OVF_EN adds the ovf port and its operand-MSB capture flops.

module serial_subtractor #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             start,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    output logic             busy,
    output logic             done,
`ifdef SERIAL_SUB_OVF_EN
    output logic             ovf,
`endif
    output logic [WIDTH-1:0] diff,
    output logic             borrow
);

    localparam int unsigned CntW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam logic [CntW-1:0] LastCnt = CntW'(WIDTH - 1);

    typedef enum logic [1:0] {StIdle, StShift, StDone} state_e;

    state_e           state_q, state_d;
    logic [WIDTH-1:0] a_sr_q, a_sr_d;
    logic [WIDTH-1:0] b_sr_q, b_sr_d;
    logic [WIDTH-1:0] res_q, res_d;
    logic [CntW-1:0]  cnt_q, cnt_d;
    logic             bff_q, bff_d;
    logic [WIDTH-1:0] diff_q, diff_d;
    logic             borrow_q, borrow_d;
`ifdef SERIAL_SUB_OVF_EN
    logic             a_msb_q, a_msb_d;
    logic             b_msb_q, b_msb_d;
    logic             ovf_q, ovf_d;
`endif

    // Full-subtractor cell on the current LSBs and the stored borrow.
    logic x_bit, y_bit, bi_bit, d_bit, bo_bit;
    assign x_bit  = a_sr_q[0];
    assign y_bit  = b_sr_q[0];
    assign bi_bit = bff_q;
    assign d_bit  = x_bit ^ y_bit ^ bi_bit;
    assign bo_bit = (~x_bit & y_bit) | (~(x_bit ^ y_bit) & bi_bit);

    always_comb begin
        state_d  = state_q;
        a_sr_d   = a_sr_q;
        b_sr_d   = b_sr_q;
        res_d    = res_q;
        cnt_d    = cnt_q;
        bff_d    = bff_q;
        diff_d   = diff_q;
        borrow_d = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
        a_msb_d  = a_msb_q;
        b_msb_d  = b_msb_q;
        ovf_d    = ovf_q;
`endif
        case (state_q)
            StIdle, StDone: begin
                if (start) begin
                    a_sr_d  = a;
                    b_sr_d  = b;
                    bff_d   = 1'b0;
                    cnt_d   = '0;
`ifdef SERIAL_SUB_OVF_EN
                    a_msb_d = a[WIDTH-1];
                    b_msb_d = b[WIDTH-1];
`endif
                    state_d = StShift;
                end else begin
                    state_d = StIdle;
                end
            end
            StShift: begin
                res_d  = {d_bit, res_q[WIDTH-1:1]};
                a_sr_d = a_sr_q >> 1;
                b_sr_d = b_sr_q >> 1;
                bff_d  = bo_bit;
                cnt_d  = cnt_q + CntW'(1);
                if (cnt_q == LastCnt) begin
                    // Final bit: publish the completed word directly from the shift path.
                    diff_d   = {d_bit, res_q[WIDTH-1:1]};
                    borrow_d = bo_bit;
`ifdef SERIAL_SUB_OVF_EN
                    ovf_d    = (a_msb_q != b_msb_q) & (d_bit != a_msb_q);
`endif
                    state_d  = StDone;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= StIdle;
            a_sr_q   <= '0;
            b_sr_q   <= '0;
            res_q    <= '0;
            cnt_q    <= '0;
            bff_q    <= 1'b0;
            diff_q   <= '0;
            borrow_q <= 1'b0;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= 1'b0;
            b_msb_q  <= 1'b0;
            ovf_q    <= 1'b0;
`endif
        end else begin
            state_q  <= state_d;
            a_sr_q   <= a_sr_d;
            b_sr_q   <= b_sr_d;
            res_q    <= res_d;
            cnt_q    <= cnt_d;
            bff_q    <= bff_d;
            diff_q   <= diff_d;
            borrow_q <= borrow_d;
`ifdef SERIAL_SUB_OVF_EN
            a_msb_q  <= a_msb_d;
            b_msb_q  <= b_msb_d;
            ovf_q    <= ovf_d;
`endif
        end
    end

    // Status decodes straight from the state register, so busy and done are glitch-free
    // and mutually exclusive.
    assign busy   = (state_q == StShift);
    assign done   = (state_q == StDone);
    assign diff   = diff_q;
    assign borrow = borrow_q;
`ifdef SERIAL_SUB_OVF_EN
    assign ovf    = ovf_q;
`endif

endmodule

// File: tb/tb_serial_subtractor.sv
// Self-checking bench for serial_subtractor (WIDTH=8) against an arithmetic reference model.
module tb_serial_subtractor;

    localparam int W = 8;

    logic         clk = 1'b0;
    logic         rst_n = 1'b0;
    logic         start = 1'b0;
    logic [W-1:0] a = '0;
    logic [W-1:0] b = '0;
    logic         busy, done, borrow;
    logic [W-1:0] diff;
`ifdef SERIAL_SUB_OVF_EN
    logic         ovf;
`endif

    int total = 0;
    int bad = 0;

    // Last published result, as predicted by the model.
    logic [W-1:0] exp_diff = '0;
    logic         exp_borrow = 1'b0;
    logic         exp_ovf = 1'b0;

    serial_subtractor #(.WIDTH(W)) dut (
        .clk    (clk),
        .rst_n  (rst_n),
        .start  (start),
        .a      (a),
        .b      (b),
        .busy   (busy),
        .done   (done),
`ifdef SERIAL_SUB_OVF_EN
        .ovf    (ovf),
`endif
        .diff   (diff),
        .borrow (borrow)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic model(input logic [W-1:0] ma, input logic [W-1:0] mb);
        int sa, sb, r;
        exp_diff   = W'((int'(ma) - int'(mb)) & ((1 << W) - 1));
        exp_borrow = (int'(ma) < int'(mb));
        sa = ma[W-1] ? int'(ma) - (1 << W) : int'(ma);
        sb = mb[W-1] ? int'(mb) - (1 << W) : int'(mb);
        r  = sa - sb;
        exp_ovf = (r > (1 << (W - 1)) - 1) || (r < -(1 << (W - 1)));
    endtask

    task automatic check_result(input string name);
        total++;
        if (diff !== exp_diff || borrow !== exp_borrow) begin
            bad++;
            $display("FAIL %s: diff=%h borrow=%b, required diff=%h borrow=%b",
                     name, diff, borrow, exp_diff, exp_borrow);
        end
`ifdef SERIAL_SUB_OVF_EN
        total++;
        if (ovf !== exp_ovf) begin
            bad++;
            $display("FAIL %s ovf: got %b, required %b", name, ovf, exp_ovf);
        end
`endif
    endtask

    // Run one operation: accept, WIDTH busy cycles holding old outputs, then one done cycle.
    task automatic run_op(input logic [W-1:0] oa, input logic [W-1:0] ob, input string name);
        a = oa;
        b = ob;
        start = 1'b1;
        tick();
        start = 1'b0;
        a = $urandom;
        b = $urandom;
        for (int i = 0; i < W; i++) begin
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== exp_diff) begin
                bad++;
                $display("FAIL %s shift cycle %0d: busy=%b done=%b diff=%h, required 1 0 %h",
                         name, i, busy, done, diff, exp_diff);
            end
            tick();
        end
        model(oa, ob);
        total++;
        if (done !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s done pulse: done=%b busy=%b, required 1 0", name, done, busy);
        end
        check_result(name);
        tick();
        total++;
        if (done !== 1'b0 || busy !== 1'b0) begin
            bad++;
            $display("FAIL %s after done: done=%b busy=%b, required 0 0", name, done, busy);
        end
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        start = 1'b0;
        tick();
        tick();
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            bad++;
            $display("FAIL reset: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow);
        end
        exp_diff = '0;
        exp_borrow = 1'b0;
        exp_ovf = 1'b0;
        check_result("reset");
        rst_n = 1'b1;
        tick();
    endtask

    task automatic test_directed();
        run_op(8'h5A, 8'h23, "sub_5a_23");
        run_op(8'h10, 8'h20, "sub_10_20");
        run_op(8'h00, 8'h00, "sub_00_00");
        run_op(8'h80, 8'h01, "sub_80_01");
        run_op(8'h7F, 8'hFF, "sub_7f_ff");
        run_op(8'hFF, 8'hFF, "sub_ff_ff");
    endtask

    task automatic test_random();
        for (int n = 0; n < 24; n++) begin
            run_op(W'($urandom), W'($urandom), "random");
        end
    endtask

    task automatic test_ignore_start();
        logic [W-1:0] prev;
        a = 8'hFF;
        b = 8'h01;
        start = 1'b1;
        tick();
        start = 1'b0;
        prev = exp_diff;
        for (int i = 0; i < W; i++) begin
            if (i == 2) begin
                a = 8'h00;
                b = 8'hFF;
                start = 1'b1;
            end else begin
                start = 1'b0;
            end
            total++;
            if (busy !== 1'b1 || done !== 1'b0 || diff !== prev) begin
                bad++;
                $display("FAIL ignore_start cycle %0d: busy=%b done=%b diff=%h", i, busy, done, diff);
            end
            tick();
        end
        start = 1'b0;
        model(8'hFF, 8'h01);
        total++;
        if (done !== 1'b1 || diff !== 8'hFE) begin
            bad++;
            $display("FAIL ignore_start result: done=%b diff=%h, required 1 fe", done, diff);
        end
        check_result("ignore_start");
        tick();
    endtask

    task automatic test_reset_mid();
        a = 8'h33;
        b = 8'h11;
        start = 1'b1;
        tick();
        start = 1'b0;
        tick();
        tick();
        tick();
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if (busy !== 1'b0 || done !== 1'b0 || diff !== '0 || borrow !== 1'b0) begin
            bad++;
            $display("FAIL reset_mid: busy=%b done=%b diff=%h borrow=%b, required all 0",
                     busy, done, diff, borrow);
        end
        exp_diff = '0;
        exp_borrow = 1'b0;
        exp_ovf = 1'b0;
        check_result("reset_mid");
        tick();
        rst_n = 1'b1;
        for (int i = 0; i < W + 2; i++) begin
            tick();
            total++;
            if (done !== 1'b0 || busy !== 1'b0) begin
                bad++;
                $display("FAIL reset_mid idle %0d: done=%b busy=%b, required 0 0", i, done, busy);
            end
        end
        run_op(8'hC4, 8'h3B, "after_reset");
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] oa, ob;
        oa = W'($urandom);
        ob = W'($urandom);
        a = oa;
        b = ob;
        start = 1'b1;
        tick();
        for (int n = 0; n < 6; n++) begin
            for (int i = 0; i < W; i++) begin
                a = W'($urandom);
                b = W'($urandom);
                total++;
                if (busy !== 1'b1 || done !== 1'b0) begin
                    bad++;
                    $display("FAIL b2b %0d cycle %0d: busy=%b done=%b", n, i, busy, done);
                end
                tick();
            end
            model(oa, ob);
            total++;
            if (done !== 1'b1 || busy !== 1'b0) begin
                bad++;
                $display("FAIL b2b %0d done: done=%b busy=%b, required 1 0", n, done, busy);
            end
            check_result("b2b");
            oa = W'($urandom);
            ob = W'($urandom);
            a = oa;
            b = ob;
            if (n == 5) start = 1'b0;
            tick();
        end
        total++;
        if (busy !== 1'b0 || done !== 1'b0) begin
            bad++;
            $display("FAIL b2b end: busy=%b done=%b, required 0 0", busy, done);
        end
    endtask

    initial begin
        test_reset();
        test_directed();
        test_random();
        test_ignore_start();
        test_reset_mid();
        test_back_to_back();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
